// File: rtl/mult_sequencer_if.sv
// Stream and multiplier-side signals of the multiplier sequencer.
// The slave view belongs to the sequencer; the master view belongs to its surroundings.
interface mult_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [7:0]  mul_in1;
   logic [7:0]  mul_in2;
   logic [15:0] mul_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;

   modport slave (
      input  in_valid, in_a, in_b, mul_out, res_ready,
      output in_ready, mul_in1, mul_in2, res_valid, res_data
   );

   modport master (
      output in_valid, in_a, in_b, mul_out, res_ready,
      input  in_ready, mul_in1, mul_in2, res_valid, res_data
   );
endinterface

// File: rtl/mult_sequencer.sv
// Operand/result sequencer around the fixed 10-cycle shift-add multiplier.
// It turns the multiplier's phase schedule into valid/ready streams with credit-based buffering.
module mult_sequencer #(
   parameter int DEPTH  = 4,
   parameter int RDEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   mult_sequencer_if.slave  bus
);

   localparam int OAW = $clog2(DEPTH);
   localparam int OCW = $clog2(DEPTH + 1);
   localparam int RAW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
   localparam int RCW = $clog2(RDEPTH + 1);

   typedef enum logic {SLOT_IDLE, SLOT_BUSY} slotState_t;

   slotState_t     r_slot;
   slotState_t     w_slotNext;

   logic [3:0]     r_phase;

   logic [7:0]     r_opA [DEPTH];
   logic [7:0]     r_opB [DEPTH];
   logic [OAW-1:0] r_opWr;
   logic [OAW-1:0] r_opRd;
   logic [OCW-1:0] r_opCount;

   logic [15:0]    r_res [RDEPTH];
   logic [RAW-1:0] r_resWr;
   logic [RAW-1:0] r_resRd;
   logic [RCW-1:0] r_resCount;

   logic           w_phase0;
   logic           w_phase9;
   logic           w_inflight;
   logic           w_credit;
   logic           w_opPush;
   logic           w_launch;
   logic           w_capture;
   logic           w_resPop;

   assign w_phase0   = (r_phase == 4'd0);
   assign w_phase9   = (r_phase == 4'd9);
   assign w_inflight = (r_slot == SLOT_BUSY);

   // A launch needs a free result slot counting the product already in flight.
   assign w_credit  = ({1'b0, r_resCount} + {{RCW{1'b0}}, w_inflight}) < (RCW + 1)'(RDEPTH);
   assign w_launch  = w_phase0 && (r_opCount != '0) && w_credit && (r_slot == SLOT_IDLE);
   assign w_capture = w_phase9 && w_inflight;

   assign bus.in_ready  = (r_opCount != OCW'(DEPTH));
   assign w_opPush      = bus.in_valid && bus.in_ready;
   assign bus.res_valid = (r_resCount != '0);
   assign w_resPop      = bus.res_valid && bus.res_ready;
   assign bus.res_data  = bus.res_valid ? r_res[r_resRd] : 16'd0;

   // Phase counter tracks the multiplier's stage counter from the shared reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= 4'd0;
      end else begin
         r_phase <= w_phase9 ? 4'd0 : r_phase + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_opPush) begin
         r_opA[r_opWr] <= bus.in_a;
         r_opB[r_opWr] <= bus.in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opWr    <= '0;
         r_opRd    <= '0;
         r_opCount <= '0;
      end else begin
         if (w_opPush) begin
            r_opWr <= r_opWr + 1'b1;
         end
         if (w_launch) begin
            r_opRd <= r_opRd + 1'b1;
         end
         case ({w_opPush, w_launch})
            2'b10:   r_opCount <= r_opCount + 1'b1;
            2'b01:   r_opCount <= r_opCount - 1'b1;
            default: r_opCount <= r_opCount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_res[r_resWr] <= bus.mul_out;
      end
   end

   // Explicit pointer wrap keeps a single-entry result FIFO legal.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resWr    <= '0;
         r_resRd    <= '0;
         r_resCount <= '0;
      end else begin
         if (w_capture) begin
            r_resWr <= (r_resWr == RAW'(RDEPTH - 1)) ? '0 : r_resWr + 1'b1;
         end
         if (w_resPop) begin
            r_resRd <= (r_resRd == RAW'(RDEPTH - 1)) ? '0 : r_resRd + 1'b1;
         end
         case ({w_capture, w_resPop})
            2'b10:   r_resCount <= r_resCount + 1'b1;
            2'b01:   r_resCount <= r_resCount - 1'b1;
            default: r_resCount <= r_resCount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= SLOT_IDLE;
      end else begin
         r_slot <= w_slotNext;
      end
   end

   // The multiplier window is busy from a launch until its product is captured.
   always_comb begin
      w_slotNext  = r_slot;
      bus.mul_in1 = 8'd0;
      bus.mul_in2 = 8'd0;
      case (r_slot)
         SLOT_IDLE: begin
            if (w_launch) begin
               w_slotNext  = SLOT_BUSY;
               bus.mul_in1 = r_opA[r_opRd];
               bus.mul_in2 = r_opB[r_opRd];
            end
         end
         SLOT_BUSY: begin
            if (w_phase9) begin
               w_slotNext = SLOT_IDLE;
            end
         end
         default: w_slotNext = SLOT_IDLE;
      endcase
   end

endmodule
